led_tone_driver: RTL and testbench
==================================

// Module: led_tone_driver
// PURPOSE
//  Output end of the player interface. button_debouncer turns a noisy press into a 1-cycle pulse;
//  this block does the reverse: it turns a 1-cycle colour command into a timed LED flash plus tone.
//  The game FSM issues one colour per handshake; the block lights the LED for ON_CYCLES, goes dark
//  for GAP_CYCLES, then returns a 1-cycle done_pulse. Sits between the game FSM and board LEDs/buzzer.
// PARAMETERS
//  ON_CYCLES   25_000_000  LED-on duration in clk cycles (>=1)
//  GAP_CYCLES  5_000_000   dark gap after ON, in cycles (0 = no gap)
//  TONE_SHIFT  0           tone half-periods = package constants >> TONE_SHIFT (sim speed-up)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  cmd_valid   in   1  command request
//  cmd_color   in   2  colour index 0..3
//  cmd_all     in   1  1 = fail flash: all four LEDs, TONE_HALF_FAIL; cmd_color ignored
//  cmd_ready   out  1  high only in IDLE
//  led         out  4  one-hot colour LED (4'b1111 for cmd_all)
//  spk         out  1  square-wave speaker drive
//  busy        out  1  high in ON or GAP
//  done_pulse  out  1  1-cycle pulse on the cycle the block re-enters IDLE
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, led=0, spk=0, busy=0, done_pulse=0, counters=0. Same
//   at mid-flash; the command in flight is dropped, no done_pulse.
//  States IDLE -> ON -> GAP -> IDLE. All outputs registered; cmd_ready = (state==IDLE).
//  IDLE: cmd_valid&cmd_ready at edge T latches colour/all and enters ON. led/busy high from T+1.
//  ON: lasts exactly ON_CYCLES cycles (led high T+1..T+ON_CYCLES), then GAP, or IDLE if GAP_CYCLES==0.
//  GAP: led=0, spk=0, busy=1 for exactly GAP_CYCLES cycles, then IDLE.
//  IDLE entry: done_pulse=1 and cmd_ready=1 in the same cycle. A new command accepted that cycle
//   re-enters ON with no dead cycle.
//  cmd_valid outside IDLE: ignored, no queueing, no error. cmd_color is sampled only at accept.
//  Counter width $clog2(max(ON_CYCLES,GAP_CYCLES)+1). Counts 0..N-1, then clears on the state change.
//  Tone: in ON, spk toggles every H cycles, H = TONE_HALF[colour] (or TONE_HALF_FAIL) >> TONE_SHIFT,
//   floor 1. Phase restarts low at ON entry; spk forced 0 outside ON.
// CONFIGURATION
//  SIMON_TONE_EN defined: tone generator instantiated and spk behaves as above.
//  SIMON_TONE_EN undefined: no tone logic, spk tied 0; LED timing and handshake are identical.
// STRUCTURE
//  simon_pkg: colour_t (2-bit enum RED/GREEN/BLUE/YELLOW), state_t (IDLE/ON/GAP),
//   TONE_HALF[0:3] and TONE_HALF_FAIL localparams, shared with the game FSM.
//  Sub-module tone_gen (enable, half-period in -> square wave), only under SIMON_TONE_EN.
//  Top level holds the FSM, duration counter and LED decode.
// TESTING  (ON_CYCLES=8, GAP_CYCLES=4, TONE_SHIFT set so H[color 1]=2)
//  1. rst 3 cycles -> led=0, spk=0, busy=0, done_pulse=0, cmd_ready=1.
//  2. cmd_valid, color=2 accepted at T -> led=4'b0100 T+1..T+8, 0 T+9..T+12, done_pulse only at T+13.
//  3. cmd_all=1, color=3 -> led=4'b1111 for 8 cycles; spk period 2*TONE_HALF_FAIL>>TONE_SHIFT.
//  4. cmd_valid held high through a flash -> cmd_ready low while busy; 2nd accept on done_pulse cycle,
//     ON starts next cycle; no extra done_pulse.
//  5. rst at T+5 mid-ON -> next cycle led=0, spk=0, busy=0, cmd_ready=1; no done_pulse afterwards.
//  6. color=1, SIMON_TONE_EN on -> spk toggles every 2 cycles in ON, low in GAP.
//     Build without it -> spk constantly 0 and test 2 timing unchanged.
//  7. GAP_CYCLES=0 build -> done_pulse at T+9, led goes 0 same cycle.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: colour/state types and tone half-periods shared by the Simon game blocks.
package simon_pkg;
  typedef enum logic [1:0] {RED, GREEN, BLUE, YELLOW} colour_t;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  localparam int TONE_W = 20;
  // Half-periods in clk cycles at 50 MHz.
  localparam logic [TONE_W-1:0] TONE_HALF [4] = '{20'd95556, 20'd75758, 20'd63776, 20'd47801};
  localparam logic [TONE_W-1:0] TONE_HALF_FAIL = 20'd200000;
  function automatic logic [TONE_W-1:0] half_period(input logic all, input colour_t c, input int shift);
    logic [TONE_W-1:0] h;
    h = (all ? TONE_HALF_FAIL : TONE_HALF[c]) >> shift;
    return h == '0 ? TONE_W'(1) : h;
  endfunction
endpackage

// File: rtl/led_tone_driver_tone_gen.sv
// tone_gen: square wave that toggles every `half` cycles while en is high; held low otherwise.
module tone_gen
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TONE_W-1:0] half,
  output logic              spk
);
  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic spk_q, spk_d, wrap;
  always_comb begin
    wrap  = cnt_q == half - TONE_W'(1);
    cnt_d = (!en || wrap) ? '0 : cnt_q + TONE_W'(1);
    spk_d = !en ? 1'b0 : (wrap ? ~spk_q : spk_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end
  assign spk = spk_q;
endmodule

// File: rtl/led_tone_driver.sv
// led_tone_driver: turns a 1-cycle colour command into a timed LED flash, dark gap and done pulse.
// Define SIMON_TONE_EN to add the speaker tone generator; otherwise spk is tied low.
module led_tone_driver
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_color,
  input  logic       cmd_all,
  output logic       cmd_ready,
  output logic [3:0] led,
  output logic       spk,
  output logic       busy,
  output logic       done_pulse
);
  localparam int MAXC     = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
  localparam int CW       = $clog2(MAXC + 1);
  localparam int GAP_LAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  state_t state_q, state_d;
  colour_t color_q, color_d;
  logic all_q, all_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] led_q, led_d;
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    all_d   = all_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = ON;
          color_d = colour_t'(cmd_color);
          all_d   = cmd_all;
        end
      end
      ON: if (cnt_q == CW'(ON_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = GAP_CYCLES == 0 ? IDLE : GAP;
      end
      GAP: if (cnt_q == CW'(GAP_LAST)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    led_d  = state_d == ON ? (all_d ? 4'b1111 : 4'b0001 << color_d) : 4'b0000;
    busy_d = state_d != IDLE;
    done_d = state_d == IDLE && state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= RED;
      all_q   <= 1'b0;
      cnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      all_q   <= all_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign cmd_ready  = state_q == IDLE;
  assign led        = led_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
`ifdef SIMON_TONE_EN
  // Gating on both current and next state restarts the phase on ON entry and drops spk on exit.
  logic tone_en;
  assign tone_en = state_q == ON && state_d == ON;
  tone_gen u_tone (
    .clk (clk),
    .rst (rst),
    .en  (tone_en),
    .half(half_period(all_q, color_q, TONE_SHIFT)),
    .spk (spk)
  );
`else
  assign spk = 1'b0;
`endif
endmodule

// File: tb/tb_led_tone_driver.sv
// tb_led_tone_driver: random + directed stimulus against a flash-timeline model, GAP=4 and GAP=0 builds.
module tb_led_tone_driver;
  import simon_pkg::*;
  localparam int ON = 8;
  localparam int SH = 15;
  localparam int GAPS [2] = '{4, 0};
  typedef struct {
    int         idx;
    logic [3:0] led;
    logic       spk, busy, done, ready;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, cmd_valid = 1'b0, cmd_all = 1'b0;
  logic [1:0] cmd_color = 2'd0;
  logic [3:0] led_o [2];
  logic spk_o [2], busy_o [2], done_o [2], rdy_o [2];
  exp_t q [$];
  int checks = 0, errors = 0, k = 0;
  int last_end [2], st [2];
  logic act [2], fa [2];
  logic [1:0] fc [2];
  always #5 clk = ~clk;
  led_tone_driver #(.ON_CYCLES(ON), .GAP_CYCLES(4), .TONE_SHIFT(SH)) dut_gap (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_color(cmd_color), .cmd_all(cmd_all),
    .cmd_ready(rdy_o[0]), .led(led_o[0]), .spk(spk_o[0]), .busy(busy_o[0]), .done_pulse(done_o[0]));
  led_tone_driver #(.ON_CYCLES(ON), .GAP_CYCLES(0), .TONE_SHIFT(SH)) dut_nogap (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_color(cmd_color), .cmd_all(cmd_all),
    .cmd_ready(rdy_o[1]), .led(led_o[1]), .spk(spk_o[1]), .busy(busy_o[1]), .done_pulse(done_o[1]));
  function automatic int tone_h(input logic a, input logic [1:0] c);
    int h;
    h = int'(a ? TONE_HALF_FAIL : TONE_HALF[c]) / (2 ** SH);
    return h < 1 ? 1 : h;
  endfunction
  task automatic chk(input string n, input int i, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", n, i, k, a, e);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [1:0] c, input logic a);
    exp_t e;
    int d, g;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_color = c; cmd_all = a;
    @(posedge clk);
    #1;
    k++;
    for (int i = 0; i < 2; i++) begin
      g = GAPS[i];
      if (r) begin
        act[i] = 1'b0;
        last_end[i] = k;
      end else if (v && k > last_end[i]) begin
        act[i] = 1'b1; st[i] = k; fa[i] = a; fc[i] = c;
        last_end[i] = k + ON + g;
      end
      d = k - st[i];
      e.idx   = i;
      e.led   = (act[i] && d < ON) ? (fa[i] ? 4'b1111 : 4'(1 << fc[i])) : 4'b0000;
`ifdef SIMON_TONE_EN
      e.spk   = act[i] && d < ON && ((d / tone_h(fa[i], fc[i])) % 2 == 1);
`else
      e.spk   = 1'b0;
`endif
      e.busy  = act[i] && d < ON + g;
      e.done  = act[i] && d == ON + g;
      e.ready = !e.busy;
      q.push_back(e);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("led", e.idx, int'(led_o[e.idx]), int'(e.led));
        chk("spk", e.idx, int'(spk_o[e.idx]), int'(e.spk));
        chk("busy", e.idx, int'(busy_o[e.idx]), int'(e.busy));
        chk("done_pulse", e.idx, int'(done_o[e.idx]), int'(e.done));
        chk("cmd_ready", e.idx, int'(rdy_o[e.idx]), int'(e.ready));
      end
    end
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      last_end[i] = 0; st[i] = 0; act[i] = 1'b0; fa[i] = 1'b0; fc[i] = 2'd0;
    end
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, 2, 0);
    repeat (14) step(0, 0, 0, 0);
    step(0, 1, 3, 1);
    repeat (14) step(0, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0);
    repeat (14) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (14) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    repeat (14) step(0, 0, 0, 0);
    repeat (800) step($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0,
                      2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    @(posedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
